// File: rtl/core_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : core_control_fsm
// Purpose  : Multi-cycle RV32I control sequencer (FETCH/DECODE/EXECUTE/MEM/WB)
//            with memory wait timeouts, illegal-opcode trap and retire counter.
// Revision : 1.0 - initial release
// ============================================================================
module core_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        imem_req,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic [1:0]  trap_cause,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd5
    } state_t;

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;

    localparam logic [1:0] c_cause_none    = 2'd0;
    localparam logic [1:0] c_cause_illegal = 2'd1;
    localparam logic [1:0] c_cause_imem    = 2'd2;
    localparam logic [1:0] c_cause_dmem    = 2'd3;

    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(MEM_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        cause_q, cause_d;
    logic [31:0]       instret_q, instret_d;

    logic [6:0] w_opcode;
    logic       w_legal;
    logic       w_is_load;
    logic       w_is_store;
    logic       w_unused_instr;

    assign w_opcode       = instr[6:0];
    assign w_is_load      = (w_opcode == c_op_load);
    assign w_is_store     = (w_opcode == c_op_store);
    assign w_unused_instr = ^instr[31:7];

    always_comb begin
        w_legal = 1'b0;
        case (w_opcode)
            c_op_r, c_op_imm, c_op_load, c_op_store, c_op_branch,
            c_op_jal, c_op_jalr, c_op_lui, c_op_auipc: w_legal = 1'b1;
            default:                                   w_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cause_d   = cause_q;
        imem_req  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'd0;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'd0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                // mem_ready in the expiry cycle takes priority over the timeout
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (cnt_q == c_timeout_last) begin
                    state_d = S_TRAP;
                    cause_d = c_cause_imem;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DECODE: begin
                if (w_legal) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d = S_TRAP;
                    cause_d = c_cause_illegal;
                end
            end

            S_EXECUTE: begin
                case (w_opcode)
                    c_op_branch: begin
                        pc_write = 1'b1;
                        pc_src   = branch_taken ? 2'd1 : 2'd0;
                        state_d  = S_FETCH;
                    end
                    c_op_load, c_op_store: begin
                        alu_src_b = 1'b1;
                        state_d   = S_MEM;
                    end
                    c_op_imm, c_op_jalr: begin
                        alu_src_b = 1'b1;
                        state_d   = S_WB;
                    end
                    c_op_auipc: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 1'b1;
                        state_d   = S_WB;
                    end
                    c_op_lui, c_op_r, c_op_jal: begin
                        state_d = S_WB;
                    end
                    default: begin
                        // instr is stable after DECODE, so this is unreachable
                        state_d = S_TRAP;
                        cause_d = c_cause_illegal;
                    end
                endcase
            end

            S_MEM: begin
                dmem_req  = 1'b1;
                dmem_we   = w_is_store;
                alu_src_b = 1'b1;
                if (mem_ready) begin
                    if (w_is_store) begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (cnt_q == c_timeout_last) begin
                    state_d = S_TRAP;
                    cause_d = c_cause_dmem;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
                // ALU operand selects chosen in EXECUTE stay valid through WB
                alu_src_a = (w_opcode == c_op_auipc);
                alu_src_b = (w_opcode == c_op_imm) || (w_opcode == c_op_jalr) ||
                            (w_opcode == c_op_auipc) || w_is_load;
                if (w_is_load) begin
                    wb_sel = 2'd1;
                end else if ((w_opcode == c_op_jal) || (w_opcode == c_op_jalr)) begin
                    wb_sel = 2'd2;
                end
                if (w_opcode == c_op_jal) begin
                    pc_src = 2'd1;
                end else if (w_opcode == c_op_jalr) begin
                    pc_src = 2'd2;
                end
            end

            S_TRAP: begin
                state_d = S_TRAP;
            end

            default: begin
                state_d = S_FETCH;
                cause_d = c_cause_none;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        if (rst) begin
            imem_req  = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            dmem_req  = 1'b0;
            dmem_we   = 1'b0;
            reg_write = 1'b0;
        end

        // every pc_write marks the retirement of the current instruction
        instret_d = instret_q + {31'd0, pc_write};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            cause_q   <= c_cause_none;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
        end
    end

    assign state      = state_q;
    assign trap_cause = cause_q;
    assign instret    = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_core_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_control_fsm
// Purpose  : Self-checking bench: directed and random instruction streams
//            compared cycle by cycle against a per-instruction phase model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_control_fsm;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 8;
    localparam logic [11:0] c_keep_selects = 12'b0001_1110_0011;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        branch_taken;
    logic        mem_ready;
    logic        imem_req, ir_write, pc_write, alu_src_a, alu_src_b;
    logic        dmem_req, dmem_we, reg_write;
    logic [1:0]  pc_src, wb_sel, trap_cause;
    logic [2:0]  state;
    logic [31:0] instret;
    logic [11:0] w_outs;

    core_control_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .instr(instr), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .imem_req(imem_req), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .reg_write(reg_write), .wb_sel(wb_sel), .state(state),
        .trap_cause(trap_cause), .instret(instret)
    );

    assign w_outs = {imem_req, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
                     dmem_req, dmem_we, reg_write, wb_sel};

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic        rdy;
        logic        bt;
        logic [2:0]  st;
        logic [11:0] outs;
        logic [1:0]  cause;
        logic [31:0] ret;
    } cyc_t;

    cyc_t        q[$];
    logic [31:0] m_ret;
    logic [1:0]  m_cause;
    logic [31:0] m_prev;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;

    logic [6:0] ops[9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                           7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [11:0] ov(input logic imem, input logic irw, input logic pcw,
                                       input logic [1:0] pcs, input logic a, input logic b,
                                       input logic dreq, input logic dwe, input logic rw,
                                       input logic [1:0] wbs);
        return {imem, irw, pcw, pcs, a, b, dreq, dwe, rw, wbs};
    endfunction

    // one expected cycle; a reset cycle masks strobes and clears the model afterwards
    task automatic push(input logic r, input logic [31:0] ins, input logic rdy, input logic bt,
                        input logic [2:0] st, input logic [11:0] outs, input bit retire);
        cyc_t c;
        c.rst = r; c.instr = ins; c.rdy = rdy; c.bt = bt; c.st = st;
        c.outs = r ? (outs & c_keep_selects) : outs;
        c.cause = m_cause; c.ret = m_ret;
        q.push_back(c);
        if (r) begin
            m_ret = 32'd0;
            m_cause = 2'd0;
        end else if (retire) begin
            m_ret = m_ret + 32'd1;
        end
    endtask

    task automatic trap_tail();
        repeat (20) push(1'b0, m_prev, 1'($urandom), 1'($urandom), 3'd5, 12'd0, 1'b0);
        push(1'b1, m_prev, 1'($urandom), 1'($urandom), 3'd5, 12'd0, 1'b0);
    endtask

    // fw/mw: wait cycles before mem_ready in FETCH/MEM; abort_mem: MEM cycle index hit by rst
    task automatic model_instr(input logic [31:0] ins, input int fw, input int mw,
                               input logic bt, input int abort_mem);
        logic [6:0] op;
        logic legal, ld, st, br, jal, jalr, a_sel, b_sel;
        logic [1:0] wbs, pcs;
        op    = ins[6:0];
        legal = 1'b0;
        for (int k = 0; k < 9; k++) if (ops[k] == op) legal = 1'b1;
        ld    = (op == 7'b0000011);
        st    = (op == 7'b0100011);
        br    = (op == 7'b1100011);
        jal   = (op == 7'b1101111);
        jalr  = (op == 7'b1100111);
        a_sel = (op == 7'b0010111);
        b_sel = ld || st || jalr || a_sel || (op == 7'b0010011);
        wbs   = ld ? 2'd1 : ((jal || jalr) ? 2'd2 : 2'd0);
        pcs   = jal ? 2'd1 : (jalr ? 2'd2 : 2'd0);

        for (int i = 0; i < fw && i < MEM_TIMEOUT; i++)
            push(1'b0, m_prev, 1'b0, 1'($urandom), 3'd0, ov(1,0,0,0,0,0,0,0,0,0), 1'b0);
        if (fw >= MEM_TIMEOUT) begin
            m_cause = 2'd2;
            trap_tail();
            return;
        end
        push(1'b0, m_prev, 1'b1, 1'($urandom), 3'd0, ov(1,1,0,0,0,0,0,0,0,0), 1'b0);
        m_prev = ins;
        push(1'b0, ins, 1'($urandom), 1'($urandom), 3'd1, 12'd0, 1'b0);
        if (!legal) begin
            m_cause = 2'd1;
            trap_tail();
            return;
        end
        push(1'b0, ins, 1'($urandom), bt, 3'd2,
             ov(0, 0, br, (br && bt) ? 2'd1 : 2'd0, a_sel, br ? 1'b0 : b_sel, 0, 0, 0, 0), br);
        if (br) return;
        if (ld || st) begin
            for (int i = 0; i <= mw && i < MEM_TIMEOUT; i++) begin
                if (i == abort_mem) begin
                    push(1'b1, ins, 1'b1, 1'($urandom), 3'd3, ov(0,0,0,0,0,1,1,st,0,0), 1'b0);
                    return;
                end
                if (i == mw)
                    push(1'b0, ins, 1'b1, 1'($urandom), 3'd3, ov(0,0,st,0,0,1,1,st,0,0), st);
                else
                    push(1'b0, ins, 1'b0, 1'($urandom), 3'd3, ov(0,0,0,0,0,1,1,st,0,0), 1'b0);
            end
            if (mw >= MEM_TIMEOUT) begin
                m_cause = 2'd3;
                trap_tail();
                return;
            end
            if (st) return;
        end
        push(1'b0, ins, 1'($urandom), 1'($urandom), 3'd4, ov(0, 0, 1, pcs, a_sel, b_sel, 0, 0, 1, wbs), 1'b1);
    endtask

    initial begin
        logic [31:0] r;
        int fw, mw;
        rst = 1'b1; instr = 32'd0; mem_ready = 1'b0; branch_taken = 1'b0;
        m_ret = 32'd0; m_cause = 2'd0; m_prev = 32'd0;

        model_instr(32'h002081B3, 0, 0, 1'b0, -1);               // add
        model_instr(32'h0000A183, 0, 3, 1'b0, -1);               // lw, 3 waits
        model_instr(32'h00208463, 0, 0, 1'b1, -1);               // beq taken
        model_instr(32'h00208463, 0, 0, 1'b0, -1);               // beq not taken
        model_instr(32'h000080E7, 0, 0, 1'b0, -1);               // jalr
        model_instr(32'h002081B3, MEM_TIMEOUT - 1, 0, 1'b0, -1); // ready in expiry cycle
        model_instr(32'h0000A183, 2, MEM_TIMEOUT - 1, 1'b0, -1);
        model_instr(32'h0020A023, 0, 3, 1'b0, 1);                // sw aborted by rst in MEM
        for (int n = 0; n < 150; n++) begin
            r  = $urandom;
            fw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, MEM_TIMEOUT - 1) : $urandom_range(0, 2);
            mw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, MEM_TIMEOUT - 1) : $urandom_range(0, 2);
            model_instr({r[31:7], ops[$urandom_range(0, 8)]}, fw, mw, 1'($urandom), -1);
        end
        model_instr(32'h002081B3, MEM_TIMEOUT, 0, 1'b0, -1);     // imem timeout
        model_instr(32'h0020A023, 1, MEM_TIMEOUT, 1'b0, -1);     // dmem timeout
        model_instr(32'h0000007F, 0, 0, 1'b0, -1);               // illegal opcode
        model_instr(32'h00000013, 1, 0, 1'b0, -1);               // recovery after reset

        repeat (2) @(posedge clk);
        foreach (q[i]) begin
            #1;
            rst          = q[i].rst;
            instr        = q[i].instr;
            mem_ready    = q[i].rdy;
            branch_taken = q[i].bt;
            @(negedge clk);
            check("state",   32'(state),      32'(q[i].st));
            check("outs",    32'(w_outs),     32'(q[i].outs));
            check("cause",   32'(trap_cause), 32'(q[i].cause));
            check("instret", instret,         q[i].ret);
            cyc++;
            @(posedge clk);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
